// File: rtl/maxii_ufm_if.sv
// Serial address/data register and command bus of the MAX II user flash block.
// program_req carries the "program" request (program is a reserved word in SystemVerilog).
interface maxii_ufm_if;
  logic arclk;
  logic ardin;
  logic arshft;
  logic drclk;
  logic drdin;
  logic drshft;
  logic drdout;
  logic program_req;
  logic erase;
  logic busy;
  logic bgpbusy;

  modport master (
    output arclk, ardin, arshft, drclk, drdin, drshft, program_req, erase,
    input  drdout, busy, bgpbusy
  );

  modport slave (
    input  arclk, ardin, arshft, drclk, drdin, drshft, program_req, erase,
    output drdout, busy, bgpbusy
  );
endinterface

// File: rtl/maxii_ufm.sv
// MAX II user flash: serial address/data registers, two-sector array with timed program/erase.
// Define MAXII_UFM_OSC_EN to build the oscillator divider (osc toggles every 4 clk when oscena=1).
module maxii_ufm #(
  parameter int address_width   = 9,
  parameter int data_width      = 16,
  parameter int osc_sim_setting = 180000,
  parameter int program_cycles  = 16,
  parameter int erase_cycles    = 64
) (
  input  logic       clk,
  input  logic       devclrn,
  maxii_ufm_if.slave bus,
  input  logic       oscena,
  output logic       osc,
  input  logic       devpor,
  input  logic       ctrl_bgpbusy,
  input  logic       sbdin,
  output logic       sbdout
);

  localparam int DEPTH   = 1 << address_width;
  localparam int HALF    = DEPTH / 2;
  localparam int MAX_CYC = (program_cycles > erase_cycles) ? program_cycles : erase_cycles;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROG  = 2'd1,
    ST_ERASE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [address_width-1:0] addr_q, addr_d;
  logic [address_width-1:0] op_addr_q, op_addr_d;
  logic [data_width-1:0]    data_q, data_d;
  logic                     ar_smp_q, ar_smp_d, ar_prv_q, ar_prv_d;
  logic                     dr_smp_q, dr_smp_d, dr_prv_q, dr_prv_d;
  logic                     ar_evt, dr_evt;
  logic                     prog_done, erase_done;

  // Array powers up erased and is deliberately outside the reset domain.
  logic [data_width-1:0] mem_q [DEPTH] = '{default: '1};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    op_addr_d = op_addr_q;
    data_d    = data_q;
    ar_smp_d  = bus.arclk;
    ar_prv_d  = ar_smp_q;
    dr_smp_d  = bus.drclk;
    dr_prv_d  = dr_smp_q;
    ar_evt    = ar_smp_q & ~ar_prv_q;
    dr_evt    = dr_smp_q & ~dr_prv_q;
    prog_done  = 1'b0;
    erase_done = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ar_evt) begin
          addr_d = bus.arshft ? {addr_q[address_width-2:0], bus.ardin} : addr_q + 1'b1;
        end
        if (dr_evt) begin
          data_d = bus.drshft ? {data_q[data_width-2:0], bus.drdin} : mem_q[addr_q];
        end
        // Erase has priority when both requests are present.
        if (bus.erase) begin
          state_d   = ST_ERASE;
          cnt_d     = CNT_W'(erase_cycles - 1);
          op_addr_d = addr_q;
        end else if (bus.program_req) begin
          state_d   = ST_PROG;
          cnt_d     = CNT_W'(program_cycles - 1);
          op_addr_d = addr_q;
        end
      end
      ST_PROG: begin
        if (cnt_q == '0) begin
          prog_done = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ERASE: begin
        if (cnt_q == '0) begin
          erase_done = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge devclrn) begin
    if (!devclrn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      op_addr_q <= '0;
      data_q    <= '0;
      ar_smp_q  <= 1'b0;
      ar_prv_q  <= 1'b0;
      dr_smp_q  <= 1'b0;
      dr_prv_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      op_addr_q <= op_addr_d;
      data_q    <= data_d;
      ar_smp_q  <= ar_smp_d;
      ar_prv_q  <= ar_prv_d;
      dr_smp_q  <= dr_smp_d;
      dr_prv_q  <= dr_prv_d;
    end
  end

  // Completion strobes come from the reset-cleared FSM, so a reset mid-operation writes nothing.
  always_ff @(posedge clk) begin
    if (prog_done) begin
      mem_q[op_addr_q] <= mem_q[op_addr_q] & data_q;
    end
    if (erase_done) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((i / HALF) == int'(op_addr_q[address_width-1])) begin
          mem_q[address_width'(i)] <= '1;
        end
      end
    end
  end

  assign bus.drdout  = data_q[data_width-1];
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.bgpbusy = 1'b0;
  assign sbdout      = 1'b0;

`ifdef MAXII_UFM_OSC_EN
  logic [1:0] div_q, div_d;
  logic       osc_q, osc_d;

  always_comb begin
    div_d = '0;
    osc_d = 1'b0;
    if (oscena) begin
      div_d = div_q + 1'b1;
      osc_d = (div_q == 2'd3) ? ~osc_q : osc_q;
    end
  end

  always_ff @(posedge clk or negedge devclrn) begin
    if (!devclrn) begin
      div_q <= '0;
      osc_q <= 1'b0;
    end else begin
      div_q <= div_d;
      osc_q <= osc_d;
    end
  end

  assign osc = osc_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, devpor, ctrl_bgpbusy, sbdin, (osc_sim_setting != 0)};
`else
  assign osc = 1'b0;

  logic unused_ok;
  assign unused_ok = &{1'b0, oscena, devpor, ctrl_bgpbusy, sbdin, (osc_sim_setting != 0)};
`endif

endmodule

// File: tb/tb_maxii_ufm.sv
// Scoreboard bench for maxii_ufm: stimulus pushes expected read words and busy lengths,
// monitors pop and compare; expectations come from an array-level flash model.
module tb_maxii_ufm;
  localparam int AW = 9;
  localparam int DW = 16;
  localparam int PC = 16;
  localparam int EC = 64;
  localparam int NW = 1 << AW;

  logic clk = 1'b0;
  logic devclrn = 1'b0;
  logic oscena = 1'b0;
  logic osc;
  logic devpor = 1'b1;
  logic ctrl_bgpbusy = 1'b0;
  logic sbdin = 1'b0;
  logic sbdout;
  logic rd_tick = 1'b0;

  maxii_ufm_if bus();

  maxii_ufm #(
    .address_width(AW), .data_width(DW), .osc_sim_setting(180000),
    .program_cycles(PC), .erase_cycles(EC)
  ) dut (
    .clk(clk), .devclrn(devclrn), .bus(bus), .oscena(oscena), .osc(osc),
    .devpor(devpor), .ctrl_bgpbusy(ctrl_bgpbusy), .sbdin(sbdin), .sbdout(sbdout)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [DW-1:0] exp_rd[$];
  int            exp_busy[$];

  logic [DW-1:0] m_mem [NW];
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Read monitor: collects 16 drdout samples per word, then scores against the queue.
  int            rd_cnt = 0;
  logic [DW-1:0] rd_acc = '0;
  always @(posedge clk) begin
    #1;
    if (rd_tick) begin
      rd_acc = {rd_acc[DW-2:0], bus.drdout};
      rd_cnt++;
      if (rd_cnt == DW) begin
        rd_cnt = 0;
        if (exp_rd.size() > 0) check("read_word", rd_acc, exp_rd.pop_front());
        else begin
          n_total++;
          $display("FAIL read_unexpected: got 0x%0h with nothing expected", rd_acc);
        end
      end
    end
  end

  // Busy monitor: measures each busy pulse; pulses cut by reset are not scored.
  int   bcnt  = 0;
  logic bprev = 1'b0;
  always @(posedge clk) begin
    #1;
    if (bus.busy) bcnt++;
    else if (bprev) begin
      if (devclrn) begin
        if (exp_busy.size() > 0) check("busy_len", bcnt, exp_busy.pop_front());
        else begin
          n_total++;
          $display("FAIL busy_unexpected: got pulse of %0d cycles with nothing expected", bcnt);
        end
      end
      bcnt = 0;
    end
    bprev = bus.busy;
  end

  task automatic strobe(input bit is_dr, input logic shft, input logic din);
    @(negedge clk);
    if (is_dr) begin bus.drshft = shft; bus.drdin = din; bus.drclk = 1'b1; end
    else       begin bus.arshft = shft; bus.ardin = din; bus.arclk = 1'b1; end
    repeat (2) @(negedge clk);
    bus.arclk = 1'b0;
    bus.drclk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic set_addr(input logic [AW-1:0] a);
    for (int i = AW - 1; i >= 0; i--) strobe(1'b0, 1'b1, a[i]);
    m_addr = a;
  endtask

  task automatic shift_data(input logic [DW-1:0] d);
    for (int i = DW - 1; i >= 0; i--) strobe(1'b1, 1'b1, d[i]);
    m_data = d;
  endtask

  task automatic dump_dr();
    for (int i = 0; i < DW; i++) begin
      @(negedge clk) rd_tick = 1'b1;
      @(negedge clk) rd_tick = 1'b0;
      strobe(1'b1, 1'b1, 1'b0);
    end
    m_data = '0;
  endtask

  task automatic read_cur();
    strobe(1'b1, 1'b0, 1'b0);
    exp_rd.push_back(m_mem[m_addr]);
    dump_dr();
  endtask

  task automatic rd(input logic [AW-1:0] a);
    set_addr(a);
    read_cur();
  endtask

  task automatic wait_busy(input logic level, input int limit, input string name);
    int n = 0;
    while (bus.busy !== level && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= limit) check(name, bus.busy, level);
  endtask

  task automatic model_erase();
    for (int i = 0; i < NW; i++)
      if ((i >> (AW - 1)) == int'(m_addr[AW-1])) m_mem[i] = '1;
  endtask

  task automatic do_prog();
    @(negedge clk) bus.program_req = 1'b1;
    exp_busy.push_back(PC);
    @(negedge clk) bus.program_req = 1'b0;
    m_mem[m_addr] = m_mem[m_addr] & m_data;
    wait_busy(1'b1, 4, "prog_start_timeout");
    wait_busy(1'b0, 4 * PC, "prog_end_timeout");
  endtask

  task automatic do_erase();
    @(negedge clk) bus.erase = 1'b1;
    exp_busy.push_back(EC);
    @(negedge clk) bus.erase = 1'b0;
    model_erase();
    wait_busy(1'b1, 4, "erase_start_timeout");
    wait_busy(1'b0, 4 * EC, "erase_end_timeout");
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    set_addr(a);
    shift_data(d);
    do_prog();
  endtask

  initial begin
    #600_000;
    $display("FAIL watchdog: got no finish within time limit expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rdat;
    int            nh;
    bus.arclk = 0; bus.ardin = 0; bus.arshft = 0;
    bus.drclk = 0; bus.drdin = 0; bus.drshft = 0;
    bus.program_req = 0; bus.erase = 0;
    for (int i = 0; i < NW; i++) m_mem[i] = '1;
    m_addr = '0;
    m_data = '0;
    repeat (3) @(negedge clk);
    devclrn = 1'b1;
    @(negedge clk);

    check("rst_busy", bus.busy, 0);
    check("rst_drdout", bus.drdout, 0);
    check("bgpbusy", bus.bgpbusy, 0);
    check("sbdout", sbdout, 0);

    rd(9'h005);
    write_word(9'h005, 16'hA5C3);
    rd(9'h005);
    write_word(9'h005, 16'hFF00);
    rd(9'h005);

    // Increment wraps from the top address to zero.
    write_word(9'h000, 16'h1234);
    set_addr(9'h1FF);
    strobe(1'b0, 1'b0, 1'b0);
    m_addr = m_addr + 1'b1;
    read_cur();

    write_word(9'h105, 16'h3C3C);
    set_addr(9'h005);
    do_erase();
    rd(9'h005);
    rd(9'h105);

    // Strobes during busy must leave both registers untouched.
    set_addr(9'h0A0);
    shift_data(16'h5A5A);
    @(negedge clk) bus.program_req = 1'b1;
    exp_busy.push_back(PC);
    @(negedge clk) bus.program_req = 1'b0;
    m_mem[m_addr] = m_mem[m_addr] & m_data;
    strobe(1'b0, 1'b1, 1'b1);
    strobe(1'b1, 1'b1, 1'b1);
    wait_busy(1'b0, 4 * PC, "lock_end_timeout");
    exp_rd.push_back(m_data);
    dump_dr();
    read_cur();

    // Request held high restarts an operation the cycle after busy falls.
    set_addr(9'h0B0);
    shift_data(16'hF0F0);
    @(negedge clk) bus.program_req = 1'b1;
    exp_busy.push_back(PC);
    exp_busy.push_back(PC);
    m_mem[m_addr] = m_mem[m_addr] & m_data;
    wait_busy(1'b1, 4, "restart_start_timeout");
    wait_busy(1'b0, 4 * PC, "restart_mid_timeout");
    @(posedge clk); #1;
    check("restart_busy", bus.busy, 1);
    @(negedge clk) bus.program_req = 1'b0;
    wait_busy(1'b0, 4 * PC, "restart_end_timeout");
    rd(9'h0B0);

    // Reset mid-program aborts without touching the array.
    set_addr(9'h0C0);
    shift_data(16'h8001);
    @(negedge clk) bus.program_req = 1'b1;
    @(negedge clk) bus.program_req = 1'b0;
    repeat (5) @(negedge clk);
    devclrn = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_drdout", bus.drdout, 0);
    repeat (3) @(negedge clk);
    devclrn = 1'b1;
    m_addr = '0;
    m_data = '0;
    read_cur();
    rd(9'h0C0);

    for (int k = 0; k < 6; k++) begin
      ra   = AW'($urandom_range(0, NW - 1));
      rdat = DW'($urandom);
      write_word(ra, rdat);
      rd(ra);
      if (k == 3) begin
        set_addr(ra);
        do_erase();
        rd(ra);
      end
    end

`ifdef MAXII_UFM_OSC_EN
    @(negedge clk) oscena = 1'b1;
    nh = 0;
    while (osc !== 1'b1 && nh < 20) begin @(posedge clk); #1; nh++; end
    if (nh >= 20) check("osc_start_timeout", osc, 1);
    for (int t = 0; t < 3; t++) begin
      logic prev;
      prev = osc;
      nh = 0;
      while (osc === prev && nh < 20) begin @(posedge clk); #1; nh++; end
      check("osc_half_period", nh, 4);
    end
    @(negedge clk) oscena = 1'b0;
    @(posedge clk); #1;
    check("osc_disabled", osc, 0);
`else
    @(negedge clk) oscena = 1'b1;
    nh = 0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #1;
      if (osc !== 1'b0) nh++;
    end
    check("osc_absent", nh, 0);
    oscena = 1'b0;
`endif

    repeat (10) @(negedge clk);
    check("sb_rd_drain", exp_rd.size(), 0);
    check("sb_busy_drain", exp_busy.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/maxii_ufm.md
MAXII_UFM -- requirements
Module: maxii_ufm

Interface
REQ-001 The block SHALL have parameter address_width, default 9: word-address width, giving 2^address_width words.
REQ-002 The block SHALL have parameter data_width, default 16: word and data-register width.
REQ-003 The block SHALL have parameter osc_sim_setting, default 180000: osc period in ps; the osc half-period is fixed at 4 clk cycles regardless of value.
REQ-004 The block SHALL have parameters program_cycles, default 16, and erase_cycles, default 64: busy durations in clk cycles.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port devclrn, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have ports arclk, ardin, arshft, inputs, 1 bit each: address-register strobe, serial data in, and shift(1)/increment(0) select.
REQ-008 The block SHALL have ports drclk, drdin, drshft, inputs, 1 bit each: data-register strobe, serial data in, and shift(1)/load(0) select.
REQ-009 The block SHALL have port drdout, output, 1 bit: data-register MSB.
REQ-010 The block SHALL have ports program and erase, inputs, 1 bit each: command requests.
REQ-011 The block SHALL have ports busy and bgpbusy, outputs, 1 bit each.
REQ-012 The block SHALL have port oscena, input, 1 bit, and port osc, output, 1 bit.
REQ-013 The block SHALL have ports devpor, ctrl_bgpbusy, sbdin, inputs, 1 bit each, and sbdout, output, 1 bit; all four are unused/tied.

Function
REQ-014 The block SHALL register arclk/drclk in clk and treat a strobe event as sampled 1 with previous sample 0; the action completes one clk after the sampled rise.
REQ-015 On an arclk event with arshft=1, the address register SHALL shift left, taking ardin into the LSB.
REQ-016 On an arclk event with arshft=0, the address register SHALL increment by 1, wrapping from 2^address_width-1 to 0.
REQ-017 On a drclk event with drshft=0, the data register SHALL load mem[address].
REQ-018 On a drclk event with drshft=1, the data register SHALL shift left, taking drdin into the LSB.
REQ-019 drdout SHALL equal data-register MSB combinationally.
REQ-020 Memory SHALL be 2^address_width x data_width with erased state all-ones, initialised erased at time zero, and not cleared by reset.
REQ-021 Memory SHALL have two sectors selected by the address MSB.
REQ-022 When idle and program=1 at a clk edge, busy SHALL go high next cycle and stay high for program_cycles.
REQ-023 At the end of a program operation, mem[address latched at start] SHALL be written as old AND data-register value (bits go 1->0 only), and busy SHALL fall in the same cycle.
REQ-024 When idle and erase=1, busy SHALL go high for erase_cycles, then every word of the sector of the latched address SHALL be set to all-ones.
REQ-025 When program and erase are both 1 while idle, erase SHALL win.
REQ-026 While busy=1, program, erase, arclk and drclk events SHALL be ignored and the address/data registers held.
REQ-027 Commands SHALL be level-sampled: a request still high when busy falls starts a new operation on the next cycle.
REQ-028 bgpbusy and sbdout SHALL be constant 0; devpor, ctrl_bgpbusy and sbdin SHALL be ignored.

Reset
REQ-029 devclrn=0 SHALL asynchronously clear the address register, data register, busy, the operation counter, the edge-detect flops and osc to 0.
REQ-030 Reset asserted mid-program/erase SHALL abort the operation and leave memory unchanged.

Configuration
REQ-031 With macro MAXII_UFM_OSC_EN defined and oscena=1, osc SHALL toggle every 4 clk cycles (period 8 clk).
REQ-032 With MAXII_UFM_OSC_EN defined and oscena=0, osc SHALL hold 0 and its divider SHALL hold cleared.
REQ-033 Without MAXII_UFM_OSC_EN, osc SHALL be constant 0, oscena SHALL be ignored, and no divider SHALL be built.

Verification
REQ-034 Read after reset: shift address 0x005 (9 strobes, arshft=1), one drclk with drshft=0, 16 strobes with drshft=1 -> drdout yields 0xFFFF MSB first.
REQ-035 Program: address 0x005, shift data 0xA5C3, pulse program -> busy high 16 cycles; readback gives 0xA5C3; programming 0xFF00 after that gives 0xA500.
REQ-036 Erase: pulse erase at address 0x005 -> busy high 64 cycles; 0x005 reads 0xFFFF; a programmed word at 0x105 is untouched.
REQ-037 Increment: address 0x1FF, arclk with arshft=0 -> address wraps to 0x000.
REQ-038 Busy lockout and reset: strobes during busy change no register; devclrn=0 mid-program -> busy=0 immediately and the target word is unchanged.
REQ-039 Oscillator: build with MAXII_UFM_OSC_EN, oscena=1 -> osc period 8 clk; set oscena=0 -> osc=0.
